div_iter: RTL and testbench

//  Iterative radix-2 restoring integer divider for RISC-V M-extension DIV/DIVU/REM/REMU.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 33 +++
 rtl/div_iter.sv | 168 ++++++++++++++++
 tb/tb_div_iter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
//   divstate_t   : controller state encoding (IDLE, BUSY, DONE)
//   FUNCT3_*     : RISC-V M-extension funct3 codes for the divide class
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divstate_t;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
//   r_i / q_i : partial remainder and dividend/quotient shift register in
//   b_i       : divisor magnitude
//   r_o / q_o : updated partial remainder and quotient shift register
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] r_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] r_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] r_sh;
    logic [XLEN:0] diff;

    // The shifted remainder keeps its carry-out bit so that divisors of
    // 2^(XLEN-1) and above still compare correctly.
    assign r_sh = {r_i, q_i[XLEN-1]};
    assign diff = r_sh - {1'b0, b_i};

    always_comb begin
        if (diff[XLEN]) begin
            r_o = r_sh[XLEN-1:0];
            q_o = {q_i[XLEN-2:0], 1'b0};
        end else begin
            r_o = diff[XLEN-1:0];
            q_o = {q_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Stalls Execute with DivBusyE while iterating, then holds the signed-fixed
// quotient and remainder for the Memory stage until the pipeline advances.
//   clk, reset      : clock, asynchronous active-high reset
//   StallM          : Memory stage stalled; keep result in DONE
//   FlushE          : squash the Execute instruction; aborts a running divide
//   DivStartE       : divide-class instruction present in Execute
//   Funct3E         : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   ForwardedSrcAE  : dividend
//   ForwardedSrcBE  : divisor
//   DivBusyE        : stall request to the hazard unit
//   QuotM, RemM     : quotient and remainder, valid in DONE
//
// state | meaning
// IDLE  | waiting for a divide; captures operands on issue
// BUSY  | one restoring step per cycle, XLEN steps
// DONE  | result presented to Memory until StallM drops
module div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallM,
    input  logic            FlushE,
    input  logic            DivStartE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            DivBusyE,
    output logic [XLEN-1:0] QuotM,
    output logic [XLEN-1:0] RemM
);
    import div_pkg::*;

    localparam int CNTW = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] XONE = {{(XLEN-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
        return ~v + XONE;
    endfunction

    divstate_t       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;

    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            b_zero, ovf;
    logic [XLEN-1:0] step_r, step_q;

    always_comb begin
        case (Funct3E)
            FUNCT3_DIV, FUNCT3_REM:   is_signed = 1'b1;
            FUNCT3_DIVU, FUNCT3_REMU: is_signed = 1'b0;
            default:                  is_signed = ~Funct3E[0];
        endcase
    end

    assign a_neg  = is_signed & ForwardedSrcAE[XLEN-1];
    assign b_neg  = is_signed & ForwardedSrcBE[XLEN-1];
    assign abs_a  = a_neg ? neg2c(ForwardedSrcAE) : ForwardedSrcAE;
    assign abs_b  = b_neg ? neg2c(ForwardedSrcBE) : ForwardedSrcBE;
    assign b_zero = (ForwardedSrcBE == '0);
    assign ovf    = is_signed && (ForwardedSrcAE == XMIN) && (ForwardedSrcBE == '1);

    div_step #(.XLEN(XLEN)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .b_i (b_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        b_d      = b_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        DivBusyE = 1'b0;

        case (state_q)
            IDLE: begin
                if (DivStartE && !FlushE) begin
                    DivBusyE = 1'b1;
                    r_d      = '0;
                    q_d      = abs_a;
                    b_d      = abs_b;
                    negq_d   = a_neg ^ b_neg;
                    negr_d   = a_neg;
                    cnt_d    = CNTW'(XLEN-1);
                    // Special cases bypass the iteration; the raw dividend is
                    // what RISC-V returns, so no sign fix is applied.
                    if (b_zero) begin
                        quot_d  = '1;
                        rem_d   = ForwardedSrcAE;
                        state_d = DONE;
                    end else if (ovf) begin
                        quot_d  = ForwardedSrcAE;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                DivBusyE = 1'b1;
                if (FlushE) begin
                    state_d = IDLE;
                end else begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == '0) begin
                        quot_d  = negq_q ? neg2c(step_q) : step_q;
                        rem_d   = negr_q ? neg2c(step_r) : step_r;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!StallM) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign QuotM = quot_q;
    assign RemM  = rem_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: table of divide vectors with hand-computed
// results, plus flush, stall, and reset sequences.
module tb_div_iter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            StallM = 1'b0;
    logic            FlushE = 1'b0;
    logic            DivStartE = 1'b0;
    logic [2:0]      Funct3E = 3'b000;
    logic [XLEN-1:0] ForwardedSrcAE = '0;
    logic [XLEN-1:0] ForwardedSrcBE = '0;
    logic            DivBusyE;
    logic [XLEN-1:0] QuotM;
    logic [XLEN-1:0] RemM;

    int checks = 0;
    int errors = 0;

    div_iter #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .StallM         (StallM),
        .FlushE         (FlushE),
        .DivStartE      (DivStartE),
        .Funct3E        (Funct3E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .DivBusyE       (DivBusyE),
        .QuotM          (QuotM),
        .RemM           (RemM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        int              busy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Issue one divide from IDLE, count the cycles DivBusyE is high, and
    // check the result in DONE. Leaves the DUT back in IDLE.
    task automatic do_div(input string name, input logic [2:0] f,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] eq, input logic [XLEN-1:0] er,
                          input int ebusy);
        int busy;
        @(negedge clk);
        Funct3E        = f;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        DivStartE      = 1'b1;
        #1;
        busy = 0;
        while (DivBusyE && busy < 200) begin
            busy++;
            @(posedge clk);
            #1;
            DivStartE = 1'b0;
            #1;
        end
        DivStartE = 1'b0;
        chk({name, " busy"}, 64'(busy), 64'(ebusy));
        chk({name, " quot"}, QuotM, eq);
        chk({name, " rem"},  RemM, er);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'b101, 64'd100, 64'd7, 64'd14, 64'd2, 65};
        vecs[1]  = '{3'b100, -64'sd7, 64'd2, -64'sd3, -64'sd1, 65};
        vecs[2]  = '{3'b110, 64'd7, -64'sd2, -64'sd3, 64'd1, 65};
        vecs[3]  = '{3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
        vecs[4]  = '{3'b100, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, -64'sd5, 1};
        vecs[5]  = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'd0, 1};
        vecs[6]  = '{3'b101, 64'd9, 64'd3, 64'd3, 64'd0, 65};
        vecs[7]  = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                     64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 65};
        vecs[8]  = '{3'b101, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'd0, 64'h8000_0000_0000_0000, 65};
        vecs[9]  = '{3'b100, -64'sd100, -64'sd7, 64'd14, -64'sd2, 65};
        vecs[10] = '{3'b101, 64'd0, 64'd5, 64'd0, 64'd0, 65};
        vecs[11] = '{3'b110, 64'h8000_0000_0000_0000, 64'd3,
                     64'hD555_5555_5555_5556, 64'hFFFF_FFFF_FFFF_FFFE, 65};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", 64'(DivBusyE), 64'd0);
        chk("reset quot", QuotM, 64'd0);
        chk("reset rem",  RemM, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].busy);
        end

        // Flush at BUSY cycle 10: results keep the previous divide's values
        @(negedge clk);
        Funct3E = 3'b101; ForwardedSrcAE = 64'd100; ForwardedSrcBE = 64'd7;
        DivStartE = 1'b1;
        @(posedge clk); #1; DivStartE = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        FlushE = 1'b1;
        #1;
        chk("flush busy before", 64'(DivBusyE), 64'd1);
        @(posedge clk); #1;
        chk("flush busy after", 64'(DivBusyE), 64'd0);
        FlushE = 1'b0;
        chk("flush quot held", QuotM, 64'hD555_5555_5555_5556);
        chk("flush rem held",  RemM, 64'hFFFF_FFFF_FFFF_FFFE);
        do_div("after flush", 3'b101, 64'd9, 64'd3, 64'd3, 64'd0, 65);

        // Stall in DONE for 4 cycles; start and flush requests are ignored there
        @(negedge clk);
        StallM = 1'b1;
        Funct3E = 3'b101; ForwardedSrcAE = 64'd100; ForwardedSrcBE = 64'd7;
        DivStartE = 1'b1;
        @(posedge clk); #1; DivStartE = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        chk("stall entry quot", QuotM, 64'd14);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            DivStartE = 1'b1;
            FlushE = 1'b1;
            ForwardedSrcAE = 64'd50;
            #1;
            chk($sformatf("stall%0d busy", k), 64'(DivBusyE), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d quot", k), QuotM, 64'd14);
            chk($sformatf("stall%0d rem", k),  RemM, 64'd2);
        end
        @(negedge clk);
        DivStartE = 1'b0;
        FlushE = 1'b0;
        StallM = 1'b0;
        @(posedge clk); #1;
        do_div("after stall", 3'b110, 64'd7, -64'sd2, -64'sd3, 64'd1, 65);

        // Reset pulse mid-BUSY
        @(negedge clk);
        Funct3E = 3'b101; ForwardedSrcAE = 64'd100; ForwardedSrcBE = 64'd7;
        DivStartE = 1'b1;
        @(posedge clk); #1; DivStartE = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset busy", 64'(DivBusyE), 64'd0);
        chk("midreset quot", QuotM, 64'd0);
        chk("midreset rem",  RemM, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_div("after reset", 3'b101, 64'd9, 64'd3, 64'd3, 64'd0, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
